// File: rtl/fir.sv
// Decimating FIR stage: keeps a TAP_COUNT-deep delay line, and after every DECIMATION_FACTOR
// accepted samples computes a signed dot product using MULT_PER_CYCLE multipliers per cycle.
// Optional build macro FIR_DEQUANT_EN: arithmetic shift right by 10 (Q10 taps) before truncation.
`timescale 1ns / 1ps

module fir #(
    parameter int unsigned TAP_COUNT         = 8,
    parameter int unsigned DECIMATION_FACTOR = 8,
    parameter int unsigned MULT_PER_CYCLE    = 4,
    parameter int unsigned DATA_WIDTH        = 32
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [TAP_COUNT*DATA_WIDTH-1:0] TAPS,
    input  logic [DATA_WIDTH-1:0]           newData,
    input  logic                            newDataAvailible,
    output logic                            in_rd_en,
    output logic [DATA_WIDTH-1:0]           dotProd,
    output logic                            done
);

    localparam int unsigned Cycles = (TAP_COUNT + MULT_PER_CYCLE - 1) / MULT_PER_CYCLE;
    localparam int unsigned AccW   = 2 * DATA_WIDTH + $clog2(TAP_COUNT);
    localparam int unsigned ProdW  = 2 * DATA_WIDTH;
    localparam int unsigned PhaseW = (Cycles > 1) ? $clog2(Cycles) : 1;
    localparam int unsigned CountW = $clog2(DECIMATION_FACTOR + 1);

    typedef enum logic [0:0] {StLoad, StCompute} state_e;

    state_e                  state_q, state_d;
    logic [CountW-1:0]       count_q, count_d;
    logic [PhaseW-1:0]       phase_q, phase_d;
    logic signed [AccW-1:0]  acc_q, acc_d;
    logic signed [AccW-1:0]  partial, sum, scaled;
    logic signed [DATA_WIDTH-1:0] lane_a, lane_b;
    logic signed [ProdW-1:0] prod;
    logic [DATA_WIDTH-1:0]   x_q [TAP_COUNT];
    logic [DATA_WIDTH-1:0]   dotprod_q, dotprod_d;
    logic                    done_q, done_d;
    logic                    accept;

    // Each lane muxes in the tap/sample pair for the current phase; unused lanes stay zero.
    always_comb begin
        partial = '0;
        lane_a  = '0;
        lane_b  = '0;
        prod    = '0;
        for (int l = 0; l < int'(MULT_PER_CYCLE); l++) begin
            lane_a = '0;
            lane_b = '0;
            for (int k = 0; k < int'(TAP_COUNT); k++) begin
                if ((k % MULT_PER_CYCLE) == l && PhaseW'(k / MULT_PER_CYCLE) == phase_q) begin
                    lane_a = TAPS[k*DATA_WIDTH +: DATA_WIDTH];
                    lane_b = x_q[k];
                end
            end
            prod    = ProdW'(lane_a) * ProdW'(lane_b);
            partial = partial + AccW'(prod);
        end
        sum = acc_q + partial;
`ifdef FIR_DEQUANT_EN
        scaled = sum >>> 10;
`else
        scaled = sum;
`endif
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        phase_d   = phase_q;
        acc_d     = acc_q;
        dotprod_d = dotprod_q;
        done_d    = 1'b0;
        in_rd_en  = 1'b0;
        accept    = 1'b0;
        unique case (state_q)
            StLoad: begin
                in_rd_en = 1'b1;
                accept   = newDataAvailible;
                if (accept) begin
                    if (count_q == CountW'(DECIMATION_FACTOR - 1)) begin
                        count_d = '0;
                        phase_d = '0;
                        acc_d   = '0;
                        state_d = StCompute;
                    end else begin
                        count_d = count_q + CountW'(1);
                    end
                end
            end
            StCompute: begin
                if (phase_q == PhaseW'(Cycles - 1)) begin
                    dotprod_d = scaled[DATA_WIDTH-1:0];
                    done_d    = 1'b1;
                    acc_d     = '0;
                    phase_d   = '0;
                    state_d   = StLoad;
                end else begin
                    acc_d   = sum;
                    phase_d = phase_q + PhaseW'(1);
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StLoad;
            count_q   <= '0;
            phase_q   <= '0;
            acc_q     <= '0;
            dotprod_q <= '0;
            done_q    <= 1'b0;
            for (int k = 0; k < int'(TAP_COUNT); k++) begin
                x_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            phase_q   <= phase_d;
            acc_q     <= acc_d;
            dotprod_q <= dotprod_d;
            done_q    <= done_d;
            if (accept) begin
                for (int k = int'(TAP_COUNT) - 1; k > 0; k--) begin
                    x_q[k] <= x_q[k-1];
                end
                x_q[0] <= newData;
            end
        end
    end

    assign dotProd = dotprod_q;
    assign done    = done_q;

endmodule

// File: tb/tb_fir.sv
// Self-checking bench for fir: directed scenarios plus random data/stalls against a
// cycle-level behavioural model (history array, sample count, countdown to output).
`timescale 1ns / 1ps

module tb_fir;

    localparam int DW = 32;
    localparam int NT = 8;
    localparam int D  = 8;
    localparam int C  = 2;

    logic             clock = 1'b0;
    logic             reset;
    logic [NT*DW-1:0] taps;
    logic [DW-1:0]    new_data;
    logic             nda;
    logic             in_rd_en;
    logic [DW-1:0]    dot_prod;
    logic             done;

    always #5 clock = ~clock;

    fir dut (
        .clock           (clock),
        .reset           (reset),
        .TAPS            (taps),
        .newData         (new_data),
        .newDataAvailible(nda),
        .in_rd_en        (in_rd_en),
        .dotProd         (dot_prod),
        .done            (done)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural reference model
    logic [DW-1:0] hist [NT];
    int            cnt = 0;
    int            pend = 0;
    logic [DW-1:0] pend_val = '0;
    logic [DW-1:0] exp_dp = '0;
    logic          exp_done = 1'b0;
    logic          exp_rd = 1'b1;
    bit            chk_on = 1'b0;

    function automatic logic [DW-1:0] model_dot();
        longint s = 0;
        for (int k = 0; k < NT; k++) begin
            s += longint'($signed(taps[k*DW +: DW])) * longint'($signed(hist[k]));
        end
        return 32'(s);
    endfunction

    always @(posedge clock) begin
        exp_done = 1'b0;
        if (reset) begin
            for (int k = 0; k < NT; k++) hist[k] = '0;
            cnt    = 0;
            pend   = 0;
            exp_dp = '0;
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                exp_done = 1'b1;
                exp_dp   = pend_val;
            end
        end else if (nda) begin
            for (int k = NT - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = new_data;
            cnt++;
            if (cnt == D) begin
                cnt      = 0;
                pend     = C;
                pend_val = model_dot();
            end
        end
        exp_rd = (pend == 0);
    end

    always @(negedge clock) begin
        if (chk_on) begin
            check("in_rd_en", 32'(in_rd_en), 32'(exp_rd));
            check("done", 32'(done), 32'(exp_done));
            check("dotProd", dot_prod, exp_dp);
        end
    end

    longint t_acc;
    longint t_first;
    longint t_done;
    logic [DW-1:0] val;

    // Present one sample and hold it until accepted; called and returns at a negedge.
    task automatic send(input logic [DW-1:0] v);
        bit   ok = 1'b0;
        logic was;
        new_data = v;
        nda      = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            was = in_rd_en;
            @(posedge clock);
            @(negedge clock);
            if (was) ok = 1'b1;
        end
        nda = 1'b0;
        check("send_accepted", 32'(ok), 32'd1);
        t_acc = longint'($time);
    endtask

    task automatic stall(input int n);
        nda = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_done(output logic [DW-1:0] v, output longint td);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (done) got = 1'b1;
            else @(negedge clock);
        end
        check("done_seen", 32'(got), 32'd1);
        v  = dot_prod;
        td = longint'($time);
    endtask

    task automatic feed_block(input int base);
        for (int i = 0; i < D; i++) begin
            send(DW'(base + i));
            if (i == 0) t_first = t_acc;
        end
    endtask

    function automatic logic [NT*DW-1:0] seq_taps();
        logic [NT*DW-1:0] t;
        for (int k = 0; k < NT; k++) t[k*DW +: DW] = DW'(NT - k);
        return t;
    endfunction

    initial begin
        reset    = 1'b1;
        nda      = 1'b0;
        new_data = '0;
        taps     = seq_taps();
        @(negedge clock);
        chk_on = 1'b1;
        check("rst_dotProd", dot_prod, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_in_rd_en", 32'(in_rd_en), 32'd1);
        reset = 1'b0;

        feed_block(1);
        wait_done(val, t_done);
        check("blk1_value", val, 32'd204);
        check("blk1_latency", 32'((t_done - t_acc) / 10), 32'(C));

        feed_block(9);
        wait_done(val, t_done);
        check("blk2_value", val, 32'd492);
        check("blk2_span", 32'((t_done - t_first) / 10), 32'(D - 1 + C));

        feed_block(17);
        wait_done(val, t_done);
        check("blk3_value", val, 32'd780);

        for (int i = 0; i < D; i++) begin
            send(DW'(25 + i));
            if (i == 0) t_first = t_acc;
            if (i == 3) stall(5);
        end
        wait_done(val, t_done);
        check("stall_value", val, 32'd1068);
        check("stall_span", 32'((t_done - t_first) / 10), 32'(D - 1 + C + 5));

        taps = '1;
        for (int i = 0; i < D; i++) send(32'd3);
        wait_done(val, t_done);
        check("neg_value", val, 32'hFFFF_FFE8);

        taps = seq_taps();
        feed_block(1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("rst_no_stale_done", 32'(done), 32'd0);
            @(negedge clock);
        end
        feed_block(1);
        wait_done(val, t_done);
        check("post_rst_value", val, 32'd204);

        for (int k = 0; k < NT; k++) taps[k*DW +: DW] = $urandom;
        for (int b = 0; b < 20; b++) begin
            for (int i = 0; i < D; i++) begin
                if ($urandom_range(3) == 0) stall(int'($urandom_range(4, 1)));
                send($urandom);
            end
        end
        repeat (6) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
